// File: rtl/morse_pkg.sv
// Shared definitions for the Morse beacon keyer: state encoding, ROM entry
// layout, element timing in Morse units and the beacon message table.
package morse_pkg;

  localparam int MSG_LEN = 11;

  localparam int DOT_U        = 1;
  localparam int DASH_U       = 3;
  localparam int ELEM_GAP_U   = 1;
  localparam int LETTER_GAP_U = 3;
  localparam int WORD_EXTRA_U = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_MARK  = 3'd2;
  localparam state_t ST_SPACE = 3'd3;
  localparam state_t ST_LGAP  = 3'd4;
  localparam state_t ST_WGAP  = 3'd5;

  // pat is left-aligned: the first element sits in pat[4], 1 = dash.
  // len = 0 marks a word space.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } rom_entry_t;

  // "VVV DE TANG"
  localparam rom_entry_t MSG_ROM [MSG_LEN] = '{
    {3'd4, 5'b00010},  // V ...-
    {3'd4, 5'b00010},  // V
    {3'd4, 5'b00010},  // V
    {3'd0, 5'b00000},  // word space
    {3'd3, 5'b10000},  // D -..
    {3'd1, 5'b00000},  // E .
    {3'd0, 5'b00000},  // word space
    {3'd1, 5'b10000},  // T -
    {3'd2, 5'b01000},  // A .-
    {3'd2, 5'b10000},  // N -.
    {3'd3, 5'b11000}   // G --.
  };

  function automatic int elem_units(input logic is_dash);
    return is_dash ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_beacon_keyer_if.sv
// Board-side signals of the beacon keyer: button in, key and activity out.
interface morse_beacon_keyer_if;

  logic btn_n;
  logic key_n;
  logic busy;
  logic busy_led;

  modport master (
    output btn_n,
    input  key_n,
    input  busy,
    input  busy_led
  );

  modport slave (
    input  btn_n,
    output key_n,
    output busy,
    output busy_led
  );

endinterface

// File: rtl/morse_beacon_keyer_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter and a one-cycle
// press pulse on each accepted release-to-press transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk_27MHz,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values together; blocking assignments would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      press_q <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Accepted after DEBOUNCE_CYCLES differing samples in a row.
        level_q <= sync_q2;
        cnt_q   <= '0;
        press_q <= ~sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/morse_beacon_keyer.sv
// Beacon keyer: a debounced button press plays "VVV DE TANG" once on an
// active-low registered key; a second press while playing aborts.
module morse_beacon_keyer #(
  parameter int UNIT_CYCLES     = 2_700_000,
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int MSG_LEN         = 11
) (
  input logic                 clk_27MHz,
  input logic                 rst,
  morse_beacon_keyer_if.slave bus
);

  import morse_pkg::*;

  localparam int TW = $clog2(UNIT_CYCLES * 4);
  localparam int IW = $clog2(MSG_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

  // Timer reload value for a span of the given number of units.
  function automatic logic [TW-1:0] span(input int units);
    return TW'(units * UNIT_CYCLES - 1);
  endfunction

  logic          press;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [IW-1:0] idx_q;
  logic [2:0]    elem_q;
  logic [4:0]    pat_q;
  logic          key_q;
  logic          busy_q;
  rom_entry_t    rom_ent;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_27MHz(clk_27MHz),
    .rst      (rst),
    .btn_n    (bus.btn_n),
    .press    (press)
  );

  assign rom_ent = MSG_ROM[idx_q];

  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      elem_q  <= '0;
      pat_q   <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else if (press && state_q != ST_IDLE) begin
      // Any press during playback aborts; it never restarts the message.
      state_q <= ST_IDLE;
      timer_q <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_q <= ST_FETCH;
            idx_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (rom_ent.len == 3'd0) begin
            // LGAP already supplied 3u of the 7u word gap.
            state_q <= ST_WGAP;
            timer_q <= span(WORD_EXTRA_U);
          end else begin
            state_q <= ST_MARK;
            elem_q  <= rom_ent.len;
            pat_q   <= rom_ent.pat;
            timer_q <= span(elem_units(rom_ent.pat[4]));
            key_q   <= 1'b0;
          end
        end

        ST_MARK: begin
          if (timer_q == '0) begin
            key_q  <= 1'b1;
            elem_q <= elem_q - 3'd1;
            pat_q  <= {pat_q[3:0], 1'b0};
            if (elem_q > 3'd1) begin
              state_q <= ST_SPACE;
              timer_q <= span(ELEM_GAP_U);
            end else begin
              state_q <= ST_LGAP;
              timer_q <= span(LETTER_GAP_U);
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        ST_SPACE: begin
          if (timer_q == '0) begin
            state_q <= ST_MARK;
            timer_q <= span(elem_units(pat_q[4]));
            key_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        ST_LGAP, ST_WGAP: begin
          if (timer_q == '0) begin
            timer_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              idx_q   <= idx_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
          key_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_n    = key_q;
  assign bus.busy     = busy_q;
  assign bus.busy_led = busy_q;

endmodule

// File: tb/tb_morse_beacon_keyer.sv
// Self-checking bench for morse_beacon_keyer: random bounce, abort and reset
// points, checked per cycle against a timeline built from Morse text.
module tb_morse_beacon_keyer;

  localparam int UNIT = 4;
  localparam int DEB  = 8;
  // Samples from the final button edge to the first busy sample:
  // 2 sync + DEB stable samples give the press, +1 for FETCH.
  localparam int LAT  = DEB + 3;

  logic clk_27MHz = 1'b0;
  logic rst       = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  bit key_tl[$];

  morse_beacon_keyer_if bus ();

  morse_beacon_keyer #(
    .UNIT_CYCLES    (UNIT),
    .DEBOUNCE_CYCLES(DEB),
    .MSG_LEN        (11)
  ) dut (
    .clk_27MHz(clk_27MHz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_27MHz = ~clk_27MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string morse_code(input byte ch);
    case (ch)
      "V":     return "...-";
      "D":     return "-..";
      "E":     return ".";
      "T":     return "-";
      "A":     return ".-";
      "N":     return "-.";
      "G":     return "--.";
      default: return "";
    endcase
  endfunction

  task automatic push_units(input int units, input bit level);
    for (int c = 0; c < units * UNIT; c++) key_tl.push_back(level);
  endtask

  // key_n per cycle from the first FETCH to the end of the last letter gap.
  task automatic build_timeline();
    string msg;
    string code;
    msg = "VVV DE TANG";
    key_tl.delete();
    for (int i = 0; i < msg.len(); i++) begin
      key_tl.push_back(1'b1);
      if (msg[i] == " ") begin
        push_units(4, 1'b1);
      end else begin
        code = morse_code(msg[i]);
        for (int j = 0; j < code.len(); j++) begin
          push_units((code[j] == "-") ? 3 : 1, 1'b0);
          push_units((j == code.len() - 1) ? 3 : 1, 1'b1);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " key_n"}, bus.key_n, 1);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " busy_led"}, bus.busy_led, 0);
  endtask

  task automatic expect_idle(input string tag, input int n);
    repeat (n) begin
      @(negedge clk_27MHz);
      check_idle(tag);
    end
  endtask

  // Alternating segments, each shorter than the debounce window.
  task automatic bounce(input string tag, input bit start, input int segs, input int fixed_len);
    int len;
    for (int s = 0; s < segs; s++) begin
      bus.btn_n = start ^ s[0];
      len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, DEB - 1));
      expect_idle(tag, len);
    end
  endtask

  // Press (btn_n=0 now), then compare every sample against the timeline.
  // Optional: release at rel_at, second press at ab_at, reset at rst_at.
  task automatic run_msg(input string name, input int n, input int rel_at,
                         input int ab_at, input int rst_at);
    int stop_at;
    bit ek;
    bit eb;
    stop_at = n + 1;
    bus.btn_n = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_27MHz);
      if (k >= stop_at || k < LAT || k >= LAT + key_tl.size()) begin
        ek = 1'b1;
        eb = 1'b0;
      end else begin
        ek = key_tl[k - LAT];
        eb = 1'b1;
      end
      check($sformatf("%s key_n@%0d", name, k), bus.key_n, ek);
      check($sformatf("%s busy@%0d", name, k), bus.busy, eb);
      check($sformatf("%s busy_led@%0d", name, k), bus.busy_led, eb);
      if (k == rel_at) bus.btn_n = 1'b1;
      if (k == ab_at) begin
        bus.btn_n = 1'b0;
        stop_at = k + LAT;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        stop_at = k + 1;
      end
      if (k == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic release_btn(input string tag);
    bounce(tag, 1'b1, 2 * int'($urandom_range(0, 3)) + 1, 0);
    expect_idle(tag, DEB + 6);
  endtask

  initial begin
    int full_n;
    int ab_at;
    int rst_at;

    build_timeline();
    full_n = LAT + key_tl.size() + 30;

    // Reset held 3 cycles while the button chatters.
    bus.btn_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_27MHz);
      check_idle($sformatf("reset@%0d", i));
      bus.btn_n = ~bus.btn_n;
    end
    rst = 1'b0;
    bus.btn_n = 1'b1;
    expect_idle("post_reset", 20);

    // 3-cycle bounce for 30 cycles, then held: one full message, no re-trigger.
    bounce("bounce", 1'b0, 10, 3);
    run_msg("full", full_n, 0, 0, 0);
    release_btn("release1");

    // Abort during the third V; the held button must not restart playback.
    ab_at = int'($urandom_range(99, 147));
    run_msg("abort", ab_at + LAT + 40, 40, ab_at, 0);
    release_btn("release2");

    // A later press plays the whole message from V again.
    bounce("bounce2", 1'b0, 2 * int'($urandom_range(1, 4)), 0);
    run_msg("restart", full_n, 0, 0, 0);
    release_btn("release3");

    // Reset during the dash of the second V.
    rst_at = int'($urandom_range(85, 96));
    run_msg("midreset", rst_at + 40, 40, 0, rst_at);
    expect_idle("after_reset", 10);

    // Fresh press after reset starts at character 0.
    run_msg("replay", full_n, 0, 0, 0);
    release_btn("release4");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
